bus_initiator: RTL and testbench
================================

Name: bus_initiator

Overview:
- Single-outstanding bus master that turns client read/write requests into transactions on the shared system bus (addr_bus, data_bus, rd_bus, wr_bus, data_mask_bus, fc_bus).
- Sits between a client (core load/store unit, DMA) and the bus.
- Holds each transaction until the addressed device asserts function-complete (fc_bus), or until a timeout expires.
- Returns read data and a status to the client.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for fc_bus before aborting with error; legal range 1..65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  1  client request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address, driven unchanged onto addr_bus.
- req_wdata  input  32  write data.
- req_mask  input  4  byte-enable mask.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  read data; valid with resp_valid on a successful read.
- resp_error  output  1  timeout flag; valid with resp_valid.
- addr_bus  output  32  bus address.
- data_bus  inout  32  bus data.
- rd_bus  output  1  read strobe.
- wr_bus  output  1  write strobe.
- data_mask_bus  output  4  bus byte mask.
- fc_bus  input  1  function complete; tri-stated by devices when idle, weak pull-down on board, so only a logic 1 counts as asserted.

Behaviour:

Reset (rst low, asynchronous):
- State goes to IDLE; rd_bus=0, wr_bus=0; data_bus released (z).
- addr_bus=0, data_mask_bus=0.
- req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0; timeout counter=0.
- Reset mid-transaction drops the strobes immediately; no response is issued.

States: IDLE, READ, WRITE, RELEASE.
- IDLE:
  - req_ready=1.
  - On a posedge with req_valid=1: latch addr, wdata, mask and write flag; clear counter; go to WRITE if req_write else READ.
  - All bus outputs are registered, so strobes appear the cycle after acceptance.
- READ:
  - rd_bus=1, wr_bus=0; addr_bus/data_mask_bus from latches; data_bus z.
  - On a posedge with fc_bus==1: capture data_bus into resp_rdata, resp_error=0, go to RELEASE.
- WRITE:
  - wr_bus=1, rd_bus=0; data_bus driven with latched wdata.
  - On a posedge with fc_bus==1: resp_error=0, go to RELEASE.
  - resp_rdata is left unchanged.
- Timeout, READ or WRITE:
  - Counter increments every cycle without fc.
  - When counter reaches TIMEOUT_CYCLES-1 with no fc: resp_error=1, resp_rdata=0, go to RELEASE.
  - fc_bus and timeout on the same edge: fc wins, no error.
- RELEASE:
  - rd_bus=wr_bus=0; data_bus z; resp_valid=1 for exactly this one cycle; req_ready=0.
  - Go to IDLE next edge.
  - This guarantees one idle bus cycle between transactions, so devices can clear their write-complete state.
- The strobes are never both 1; rd_bus ^ wr_bus always holds during a transaction.
- req_ready=0 in READ, WRITE and RELEASE; a req_valid presented then is ignored, and the client must hold it.
- The client cannot stall responses: resp_valid is a pulse, and resp_rdata/resp_error hold until the next response.
- Minimum latency, acceptance edge to resp_valid:
  - Read against a combinational-fc device: 2 cycles.
  - Write against a device with registered fc: 3 cycles.
- Back-to-back throughput: one transaction per (latency+1) cycles.
- data_bus is only driven in WRITE, giving no contention with device read drivers.

Test Plan:
1. Read: device model returns 0xA5A5_1234 at 0x4 with fc asserted combinationally while rd_bus=1.
   - Accept read 0x4 mask 0xF → rd_bus high 1 cycle later, resp_valid 2 cycles after accept, resp_rdata=0xA5A5_1234, resp_error=0.
2. Write: device latches on the first wr_bus edge and asserts fc the next cycle.
   - Write 0x0 data 0x0000_0001 mask 0x1 → data_bus=0x0000_0001 and data_mask_bus=0x1 while wr_bus=1.
   - resp_valid 3 cycles after accept, error 0; wr_bus low in RELEASE.
3. Timeout: TIMEOUT_CYCLES=8, read an unmapped address, fc stays z.
   - rd_bus held exactly 8 cycles → resp_valid with resp_error=1, resp_rdata=0.
4. Back-to-back: req_valid held high with a write then a read.
   - One RELEASE cycle with rd_bus=wr_bus=0 and data_bus z between them.
   - Second request accepted only when req_ready returns to 1.
5. Asynchronous reset: rst driven low mid-WRITE, between clock edges.
   - wr_bus=0 and data_bus z immediately, no resp_valid; after release, req_ready=1.
6. Coincident fc and timeout: fc_bus rises on the same edge the counter hits TIMEOUT_CYCLES-1.
   - resp_error=0, data captured.

Source files
------------

// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding system-bus master.
// Accepts one client request at a time, holds the bus strobes until the
// addressed device raises fc_bus (or a timeout expires), then returns a
// one-cycle response and leaves the bus idle for one cycle.
module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // client side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  // system bus side
  output logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  output logic        rd_bus,
  output logic        wr_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Counter value on which a transaction without fc is abandoned.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [31:0] wdata_q;
  logic        fc_seen;
  logic        timed_out;
  logic        accept;

  // fc_bus floats with a weak pull-down; only a clean 1 completes a cycle.
  assign fc_seen   = (fc_bus == 1'b1);
  assign timed_out = (cnt == TIMEOUT_LAST);
  assign accept    = (state == IDLE) && req_valid;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RELEASE);

  // Only the initiator drives data in WRITE; devices drive it during READ.
  assign data_bus = wr_bus ? wdata_q : 'z;

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so every path writes state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:        if (req_valid) state_next = req_write ? WRITE : READ;
      READ, WRITE: if (fc_seen || timed_out) state_next = RELEASE;
      RELEASE:     state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // State register plus registered strobes, so the bus never sees decode glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
      state  <= IDLE;
      rd_bus <= 1'b0;
      wr_bus <= 1'b0;
    end else begin
      state  <= state_next;
      rd_bus <= (state_next == READ);
      wr_bus <= (state_next == WRITE);
    end
  end

  // Request latches and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_bus      <= '0;
      data_mask_bus <= '0;
      wdata_q       <= '0;
      cnt           <= '0;
    end else if (accept) begin
      addr_bus      <= req_addr;
      data_mask_bus <= req_mask;
      wdata_q       <= req_wdata;
      cnt           <= '0;
    end else if ((state == READ || state == WRITE) && !fc_seen && !timed_out) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Response capture: fc takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (state == READ || state == WRITE) begin
      if (fc_seen) begin
        resp_error <= 1'b0;
        if (state == READ) resp_rdata <= data_bus;
      end else if (timed_out) begin
        resp_error <= 1'b1;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed testbench for bus_initiator with a small bus device model.
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  logic        fc_bus;

  int n_checks = 0;
  int n_errors = 0;

  // device model controls
  logic        dev_wr_en;
  logic        force_fc;
  logic        wr_fc_q     = 1'b0;
  logic [31:0] dev_wdata_q = 32'h0;
  logic        dev_drive;
  logic [31:0] dev_rdata;

  bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_mask      (req_mask),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .addr_bus      (addr_bus),
    .data_bus      (data_bus),
    .rd_bus        (rd_bus),
    .wr_bus        (wr_bus),
    .data_mask_bus (data_mask_bus),
    .fc_bus        (fc_bus)
  );

  always #5 clk = ~clk;

  // Device: combinational read response at 0x4, registered write completion,
  // plus a forced fc/data source for the coincidence test.
  always_comb begin
    dev_drive = (rd_bus && addr_bus == 32'h4) || force_fc;
    dev_rdata = force_fc ? 32'hDEAD_BEEF : 32'hA5A5_1234;
    fc_bus    = (rd_bus && addr_bus == 32'h4) || wr_fc_q || force_fc;
  end

  assign data_bus = dev_drive ? dev_rdata : 'z;

  always @(posedge clk) begin
    wr_fc_q <= dev_wr_en && wr_bus;
    if (wr_bus) dev_wdata_q <= data_bus;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic released();
    return (data_bus === 32'hzzzz_zzzz) || (data_bus === 32'h0);
  endfunction

  task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_mask  = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_mask  = '0;
    dev_wr_en = 1'b1;
    force_fc  = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_rd", rd_bus, 0);
    check("rst_wr", wr_bus, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_error", resp_error, 0);
    check("rst_addr", addr_bus, 0);
    check("rst_mask", data_mask_bus, 0);
    check("rst_data_z", released(), 1);
    rst = 1'b1;
    step();

    // 1. read with combinational fc
    request(1'b0, 32'h4, 32'h0, 4'hF);
    check("rd_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("rd_strobe", rd_bus, 1);
    check("rd_wr_low", wr_bus, 0);
    check("rd_addr", addr_bus, 32'h4);
    check("rd_mask", data_mask_bus, 4'hF);
    check("rd_no_resp_yet", resp_valid, 0);
    step();
    check("rd_resp_valid", resp_valid, 1);
    check("rd_rdata", resp_rdata, 32'hA5A5_1234);
    check("rd_error", resp_error, 0);
    check("rd_release_rd", rd_bus, 0);
    check("rd_release_ready", req_ready, 0);
    step();
    check("rd_pulse_end", resp_valid, 0);
    check("rd_idle_ready", req_ready, 1);

    // 2. write with registered fc
    request(1'b1, 32'h0, 32'h0000_0001, 4'h1);
    step();
    req_valid = 1'b0;
    check("wr_strobe", wr_bus, 1);
    check("wr_rd_low", rd_bus, 0);
    check("wr_data", data_bus, 32'h0000_0001);
    check("wr_mask", data_mask_bus, 4'h1);
    check("wr_no_resp_1", resp_valid, 0);
    step();
    check("wr_strobe_2", wr_bus, 1);
    check("wr_no_resp_2", resp_valid, 0);
    step();
    check("wr_resp_valid", resp_valid, 1);
    check("wr_error", resp_error, 0);
    check("wr_release_wr", wr_bus, 0);
    check("wr_release_rd", rd_bus, 0);
    check("wr_release_z", released(), 1);
    check("wr_rdata_kept", resp_rdata, 32'hA5A5_1234);
    check("wr_dev_data", dev_wdata_q, 32'h0000_0001);
    step();
    check("wr_idle_ready", req_ready, 1);

    // 3. timeout on unmapped read
    request(1'b0, 32'h100, 32'h0, 4'hF);
    step();
    req_valid = 1'b0;
    n = 0;
    while (rd_bus && n < 20) begin
      n++;
      step();
    end
    check("to_rd_cycles", n, 8);
    check("to_resp_valid", resp_valid, 1);
    check("to_error", resp_error, 1);
    check("to_rdata", resp_rdata, 0);
    step();
    check("to_idle_ready", req_ready, 1);

    // 6. fc on the same edge as the timeout
    request(1'b0, 32'h100, 32'h0, 4'hF);
    step();
    req_valid = 1'b0;
    repeat (7) step();
    check("co_still_rd", rd_bus, 1);
    check("co_no_resp", resp_valid, 0);
    force_fc = 1'b1;
    step();
    force_fc = 1'b0;
    check("co_resp_valid", resp_valid, 1);
    check("co_error", resp_error, 0);
    check("co_rdata", resp_rdata, 32'hDEAD_BEEF);
    step();

    // 4. back-to-back: write then read with req_valid held
    request(1'b1, 32'h8, 32'h0000_005A, 4'hC);
    step();
    request(1'b0, 32'h4, 32'h0, 4'hF);
    check("bb_wr_strobe", wr_bus, 1);
    check("bb_busy", req_ready, 0);
    step();
    check("bb_wr_hold", wr_bus, 1);
    check("bb_ignored", rd_bus, 0);
    step();
    check("bb_wr_resp", resp_valid, 1);
    check("bb_gap_rd", rd_bus, 0);
    check("bb_gap_wr", wr_bus, 0);
    check("bb_gap_z", released(), 1);
    check("bb_gap_ready", req_ready, 0);
    check("bb_dev_data", dev_wdata_q, 32'h0000_005A);
    step();
    check("bb_ready_back", req_ready, 1);
    check("bb_idle_rd", rd_bus, 0);
    step();
    req_valid = 1'b0;
    check("bb_rd_strobe", rd_bus, 1);
    check("bb_rd_addr", addr_bus, 32'h4);
    step();
    check("bb_rd_resp", resp_valid, 1);
    check("bb_rd_data", resp_rdata, 32'hA5A5_1234);
    check("bb_rd_error", resp_error, 0);
    step();

    // 5. asynchronous reset mid-write
    dev_wr_en = 1'b0;
    request(1'b1, 32'h20, 32'hFFFF_0000, 4'hF);
    step();
    req_valid = 1'b0;
    check("ar_wr_strobe", wr_bus, 1);
    check("ar_wr_data", data_bus, 32'hFFFF_0000);
    #2;
    rst = 1'b0;
    #1;
    check("ar_wr_dropped", wr_bus, 0);
    check("ar_data_z", released(), 1);
    check("ar_no_resp", resp_valid, 0);
    check("ar_ready", req_ready, 1);
    step();
    rst = 1'b1;
    step();
    check("ar_after_ready", req_ready, 1);
    check("ar_after_resp", resp_valid, 0);
    check("ar_after_wr", wr_bus, 0);
    step();
    check("ar_late_resp", resp_valid, 0);
    dev_wr_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
